// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Responder end of the data-cache CacheReq/CacheResp interface.
//               Backs requests with a word-organised on-chip RAM, answers each
//               accepted request after a fixed LATENCY, and reports access
//               faults (misalignment, out-of-range address, bad size code).
//               Optional macro MEM_RESPONDER_STALL_EN: when defined, a 16-bit
//               LFSR pseudo-randomly withholds req_ready while idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH      = 1024,
    parameter int          LATENCY    = 2,
    localparam int         FAULT_TY_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [1:0]            req_wmask,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [FAULT_TY_W-1:0] resp_errty
);

    // MemSize encoding carried on req_wmask; 2'b11 is undefined.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // FaultTy value; access faults are the only kind this block can raise.
    localparam logic [FAULT_TY_W-1:0] FE_ACCESS_FAULT = FAULT_TY_W'(1);

    localparam int          IDX_W       = $clog2(DEPTH);
    localparam logic [31:0] RANGE_BYTES = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_LOAD    = 4'(LATENCY - 1);

    // State machine encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [3:0]       r_cnt;

    logic             w_ready_idle;
    logic             w_accept;
    logic             w_enter_resp;

    logic [31:0]      w_rel;
    logic             w_in_range;
    logic             w_size_ok;
    logic             w_misaligned;
    logic             w_fault;
    logic [1:0]       w_offset;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_wlane;
    logic             w_store;

    logic [31:0]      w_rd_word;
    logic [31:0]      w_rd_shift;
    logic [31:0]      w_load_data;

    logic [31:0]      r_pend_rdata;
    logic             r_pend_error;

    logic [31:0]      r_mem [DEPTH];

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0]      r_lfsr;
    logic             w_lfsr_fb;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Free-running stall pattern generator, advances every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_ready_idle = r_lfsr[0];
`else
    assign w_ready_idle = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Request decode: address range, alignment, size and lane selection
    // ------------------------------------------------------------------
    assign w_accept   = req_valid & req_ready;
    assign w_rel      = req_addr - BASE_ADDR;
    assign w_in_range = (req_addr >= BASE_ADDR) && (w_rel < RANGE_BYTES);
    assign w_offset   = req_addr[1:0];
    assign w_idx      = w_rel[IDX_W+1:2];

    // Decode the size code into byte enables, replicated store data and alignment.
    always_comb begin
        w_size_ok    = 1'b1;
        w_misaligned = 1'b0;
        w_be         = 4'b0000;
        w_wlane      = req_wdata;
        case (req_wmask)
            SIZE_B: begin
                w_be    = 4'b0001 << w_offset;
                w_wlane = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
                w_misaligned = w_offset[0];
                w_be         = 4'b0011 << w_offset;
                w_wlane      = {2{req_wdata[15:0]}};
            end
            SIZE_W: begin
                w_misaligned = |w_offset;
                w_be         = 4'b1111;
                w_wlane      = req_wdata;
            end
            default: begin
                w_size_ok = 1'b0;
            end
        endcase
    end

    assign w_fault = ~w_in_range | w_misaligned | ~w_size_ok;
    assign w_store = w_accept & req_wen & ~w_fault;

    // ------------------------------------------------------------------
    // RAM: stores commit on the accept edge; loads read the same edge, so
    // a later load always observes an earlier store.
    // ------------------------------------------------------------------

    // Byte-lane write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    assign w_rd_word  = r_mem[w_idx];
    assign w_rd_shift = w_rd_word >> {w_offset, 3'b000};

    // Right-align and zero-extend the loaded field.
    always_comb begin
        w_load_data = 32'h0;
        case (req_wmask)
            SIZE_B:  w_load_data = {24'h0, w_rd_shift[7:0]};
            SIZE_H:  w_load_data = {16'h0, w_rd_shift[15:0]};
            default: w_load_data = w_rd_shift;
        endcase
    end

    // Capture the response payload at the accept edge; stores and faults return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_rdata <= 32'h0;
            r_pend_error <= 1'b0;
        end else if (w_accept) begin
            r_pend_rdata <= (w_fault | req_wen) ? 32'h0 : w_load_data;
            r_pend_error <= w_fault;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> WAIT on accept, WAIT -> RESP when the count expires.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: req_ready  = w_ready_idle;
            ST_RESP: resp_valid = 1'b1;
            default: begin
                req_ready  = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    // Latency counter: loads on accept, counts down while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response payload registers; updated only when a response is issued so
    // they hold between pulses.
    assign w_enter_resp = (r_state != ST_RESP) && (w_state_next == ST_RESP);

    // Load the visible response fields on entry to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= 32'h0;
            resp_error <= 1'b0;
        end else if (w_enter_resp) begin
            resp_rdata <= r_pend_rdata;
            resp_error <= r_pend_error;
        end
    end

    assign resp_errty = FE_ACCESS_FAULT;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder: directed vector table,
//               multi-cycle corner sequences (AMO turnaround, reset in WAIT)
//               and random traffic against a byte-addressed reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int          DEPTH   = 1024;
    localparam int          LATENCY = 2;
    localparam logic [2:0]  FE_ACC  = 3'd1;
    localparam logic [1:0]  SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_wmask = 2'b00;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [2:0]  resp_errty;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference memory: one byte per byte address; absent entries are unknown.
    logic [7:0] ref_mem [longint];

    mem_responder #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .resp_errty (resp_errty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout, expected DUT event", nm);
    endtask

    // Reference model: architectural effect of one request.
    function automatic void model(input bit wen, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [1:0] sz,
                                  output logic [31:0] rd, output bit err,
                                  output bit known);
        int     n;
        longint a;
        n = (sz == SB) ? 1 : (sz == SH) ? 2 : (sz == SW) ? 4 : 0;
        a = longint'(addr);
        rd = 32'h0;
        known = 1'b1;
        err = (n == 0) || (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH);
        if (!err && (a % n) != 0) err = 1'b1;
        if (err) return;
        for (int i = 0; i < n; i++) begin
            if (wen) begin
                ref_mem[a + i] = wd[8*i +: 8];
            end else if (ref_mem.exists(a + i)) begin
                rd[8*i +: 8] = ref_mem[a + i];
            end else begin
                known = 1'b0;
            end
        end
    endfunction

    // One complete request/response; checks latency, pulse width and hold.
    task automatic run_txn(input bit wen, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] sz,
                           output logic [31:0] rd, output logic er,
                           output int acc_cyc, output int rsp_cyc,
                           output logic [31:0] m_rd, output bit m_err, output bit m_known);
        int tries;
        int lat;
        tries = 0;
        lat = -1;
        rd = 32'h0;
        er = 1'b0;
        acc_cyc = -1;
        rsp_cyc = -1;
        model(wen, addr, wd, sz, m_rd, m_err, m_known);
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = sz;
        while (!req_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            fail_now("accept_timeout");
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        for (int k = 1; k <= LATENCY + 8; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat = k;
                rsp_cyc = cyc;
                break;
            end
        end
        if (lat < 0) begin
            fail_now("resp_timeout");
            return;
        end
        rd = resp_rdata;
        er = resp_error;
        chk("latency", lat, LATENCY);
        chk("errty", {29'h0, resp_errty}, {29'h0, FE_ACC});
        @(posedge clk);
        #1;
        chk("pulse_width", {31'h0, resp_valid}, 32'h0);
        chk("rdata_hold", resp_rdata, rd);
    endtask

    typedef struct {
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  sz;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    initial begin : main
        vec_t        tbl[$];
        logic [31:0] rd, m_rd;
        logic        er;
        bit          m_err, m_known, seen;
        int          acc, rsp, acc2, rsp2;
        string       nm;

        // wen, addr, wdata, size, expected rdata, expected error
        tbl.push_back('{1, 32'h8000_0000, 32'hDEADBEEF, SW, 32'h0,        0});
        tbl.push_back('{0, 32'h8000_0000, 32'h0,        SW, 32'hDEADBEEF, 0});
        tbl.push_back('{1, 32'h8000_0000, 32'h11223344, SW, 32'h0,        0});
        tbl.push_back('{1, 32'h8000_0003, 32'h000000AA, SB, 32'h0,        0});
        tbl.push_back('{0, 32'h8000_0000, 32'h0,        SW, 32'hAA223344, 0});
        tbl.push_back('{0, 32'h8000_0003, 32'h0,        SB, 32'h000000AA, 0});
        tbl.push_back('{0, 32'h8000_0002, 32'h0,        SH, 32'h0000AA22, 0});
        tbl.push_back('{0, 32'h8000_0002, 32'h0,        SW, 32'h0,        1});
        tbl.push_back('{1, 32'h8000_0001, 32'h0000FFFF, SH, 32'h0,        1});
        tbl.push_back('{0, 32'h8000_0000, 32'h0,        SW, 32'hAA223344, 0});
        tbl.push_back('{0, 32'h8000_1000, 32'h0,        SW, 32'h0,        1});
        tbl.push_back('{0, 32'h7FFF_FFFC, 32'h0,        SW, 32'h0,        1});
        tbl.push_back('{1, 32'h8000_0FFC, 32'h0BADF00D, SW, 32'h0,        0});
        tbl.push_back('{0, 32'h8000_0FFC, 32'h0,        SW, 32'h0BADF00D, 0});
        tbl.push_back('{0, 32'h8000_0000, 32'h0,        SX, 32'h0,        1});
        tbl.push_back('{1, 32'h8000_0001, 32'h12345677, SB, 32'h0,        0});
        tbl.push_back('{0, 32'h8000_0000, 32'h0,        SH, 32'h00007744, 0});

        // Reset values.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_error", {31'h0, resp_error}, 32'h0);
        chk("rst_errty", {29'h0, resp_errty}, {29'h0, FE_ACC});
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        foreach (tbl[i]) begin
            run_txn(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].sz,
                    rd, er, acc, rsp, m_rd, m_err, m_known);
            nm = $sformatf("vec%0d_rdata", i);
            chk(nm, rd, tbl[i].exp_rd);
            nm = $sformatf("vec%0d_error", i);
            chk(nm, {31'h0, er}, {31'h0, tbl[i].exp_err});
        end

        // AMO turnaround: store issued right after the load's response.
        run_txn(1, 32'h8000_0010, 32'd5, SW, rd, er, acc, rsp, m_rd, m_err, m_known);
        run_txn(0, 32'h8000_0010, 32'd0, SW, rd, er, acc, rsp, m_rd, m_err, m_known);
        chk("amo_load", rd, 32'd5);
        run_txn(1, 32'h8000_0010, rd + 32'd7, SW, rd, er, acc2, rsp2, m_rd, m_err, m_known);
        chk("amo_accept_edge", acc2, rsp + 2);
        run_txn(0, 32'h8000_0010, 32'd0, SW, rd, er, acc, rsp, m_rd, m_err, m_known);
        chk("amo_result", rd, 32'h0000000C);

        // Reset while a store waits for its response.
        model(1, 32'h8000_0020, 32'h1234, SW, m_rd, m_err, m_known);
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0020;
        req_wdata = 32'h0000_1234;
        req_wmask = SW;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdata", resp_rdata, 32'h0);
        chk("midrst_ready", {31'h0, req_ready}, 32'h1);
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            seen |= resp_valid;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LATENCY + 2) begin
            @(posedge clk);
            #1;
            seen |= resp_valid;
        end
        chk("midrst_no_resp", {31'h0, seen}, 32'h0);
        run_txn(0, 32'h8000_0020, 32'd0, SW, rd, er, acc, rsp, m_rd, m_err, m_known);
        chk("midrst_store_kept", rd, 32'h0000_1234);

        // Random traffic in a small window, checked against the model.
        for (int w = 0; w < 16; w++) begin
            run_txn(1, BASE + 32'(4 * w), $urandom, SW, rd, er, acc, rsp, m_rd, m_err, m_known);
        end
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            bit          wen;
            int          sel;
            wen = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            sz  = 2'($urandom_range(0, 3));
            if (sel == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
            else if (sel == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
            else               a = BASE + 32'($urandom_range(0, 63));
            run_txn(wen, a, $urandom, sz, rd, er, acc, rsp, m_rd, m_err, m_known);
            chk("rand_error", {31'h0, er}, {31'h0, m_err});
            if (m_known) chk("rand_rdata", rd, m_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the data-cache request/response interface (the CacheReq/CacheResp pair) that the memory stage drives as initiator.
- Backs the interface with a word-organised on-chip RAM, has a configurable fixed latency, and reports access faults.
- Used as a simulation/FPGA data memory and as the golden responder when verifying memory-stage LR/SC/AMO sequencing.
- Ports are the flattened CacheReq/CacheResp fields.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 2, cycles from request accept to response pulse; legal range is 1 to 15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- req_valid  in  1  CacheReq.valid.
- req_ready  out  1  CacheReq.ready.
- req_wen  in  1  CacheReq.wen; 1 = store, 0 = load.
- req_addr  in  32  CacheReq.addr, byte address.
- req_wdata  in  32  CacheReq.wdata, right-aligned store data.
- req_wmask  in  2  CacheReq.wmask, MemSize: SIZE_B, SIZE_H, SIZE_W.
- resp_valid  out  1  CacheResp.valid, one-cycle pulse.
- resp_rdata  out  32  CacheResp.rdata, right-aligned, zero-extended.
- resp_error  out  1  CacheResp.error.
- resp_errty  out  $bits(FaultTy)  CacheResp.errty; only FE_ACCESS_FAULT is ever driven.

Behaviour:
- Reset values: state IDLE, req_ready 1 (subject to the optional feature), resp_valid 0, resp_rdata 0, resp_error 0, resp_errty FE_ACCESS_FAULT, latency counter 0. RAM contents are not reset.
- States:
  - IDLE: req_ready = 1. When req_valid & req_ready at a clock edge, the request is accepted and the block moves to WAIT. At most one request is outstanding.
  - WAIT: req_ready = 0. The counter loads LATENCY-1 on accept and decrements each cycle. At 0 the block moves to RESP. With LATENCY = 1 it goes directly to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, req_ready = 0, then back to IDLE. resp_valid therefore rises exactly LATENCY cycles after the accept edge.
- The initiator drops req_valid after the accept. req_valid seen in WAIT or RESP is ignored.
- Fault check, evaluated at the accept edge:
  - Misaligned (SIZE_H with addr[0] = 1, SIZE_W with addr[1:0] != 0) → fault.
  - addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH → fault.
  - Undefined wmask encoding → fault.
  - On a fault: no RAM access, and the response carries resp_error = 1, errty FE_ACCESS_FAULT, rdata 0.
- Word index = (addr - BASE_ADDR) >> 2. Byte offset = addr[1:0].
- Store: commits at the accept edge.
  - SIZE_B writes wdata[7:0] into byte lane offset.
  - SIZE_H writes wdata[15:0] into lanes offset and offset+1.
  - SIZE_W writes the full word.
  - Other lanes are unchanged. Response rdata is 0.
- Load: the word is read at the accept edge and shifted right by 8*offset.
  - SIZE_B returns the byte zero-extended to 32 bits.
  - SIZE_H returns the halfword zero-extended.
  - SIZE_W returns the whole word.
  - Sign extension is the initiator's job.
- Ordering: a load accepted after a store always observes that store.
- resp_rdata, resp_error and resp_errty hold their values after the pulse until the next response. Only resp_valid is a pulse.
- Back-to-back traffic: after RESP the block returns to IDLE; earliest next accept is the cycle after the response (AMO read-then-write pattern).
- Reset mid-operation: the outstanding request is dropped with no response. A store already accepted stays committed.

Optional Feature:
- Macro: MEM_RESPONDER_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded 16'hACE1 on reset and advances every cycle.
  - In IDLE, req_ready = lfsr[0]; in other states req_ready stays 0.
  - This exercises the initiator's wait-for-ready path.
- Undefined: no LFSR exists, and req_ready = 1 throughout IDLE.

Test Plan:
- SW 32'hDEADBEEF to 8000_0000 → resp_valid exactly LATENCY cycles after accept, error 0. Then LW from 8000_0000 → rdata DEADBEEF.
- SB 32'h000000AA to 8000_0003 over word 11223344 → LW returns AA223344. LBU 8000_0003 → rdata 000000AA. LHU 8000_0002 → rdata 0000AA22.
- LW 8000_0002 → error 1, errty FE_ACCESS_FAULT, rdata 0. SH to 8000_0001 → error 1, and the RAM word is unchanged.
- LW 8000_1000 (DEPTH = 1024) and LW 7FFF_FFFC → both return access fault.
- AMO pattern, with the RAM word 8000_0010 preloaded to 5: LW 8000_0010, then SW of 5+7 issued in the cycle after resp_valid → accepted immediately, and a later LW returns 0000000C.
- Deassert rst_n in WAIT after an SW of 1234 to 8000_0020 → no resp_valid. After reset, LW 8000_0020 returns 00001234.
